uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver. It is the successor to the team's basic receiver. It adds:
- a clocked design with a tick enable
- mid-bit sampling with false-start rejection
- configurable parity and stop bits
- framing-error, parity-error, overrun and break flags
- a valid/ready output handshake

It sits between the pad synchroniser domain and the UART RX FIFO/host interface. It is driven by the shared baud-tick generator.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, rx_tick pulses per bit period (even, >=4)
STOP_BITS, 1, stop bits checked (1 or 2)
PARITY_EN, 0, 1 = a parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
SYNC_STAGES, 2, flops in the rx input synchroniser (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx  in  1  serial line, idle high, asynchronous
rx_tick  in  1  one-clk pulse per oversample period
rx_dout  out  DATA_BITS  received word
rx_valid  out  1  rx_dout and the error flags are valid
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
parity_err  out  1  parity mismatch for the word held in rx_dout
frame_err  out  1  a stop bit sampled low for the held word
break_det  out  1  the held word was a break condition
overrun  out  1  a frame completed while rx_valid was high; that frame was dropped
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE, all counters 0; rx_dout=0; rx_valid, parity_err, frame_err, break_det, overrun, busy all 0; synchroniser flops preset to 1. Reset mid-frame aborts the frame with no output.
- rx passes through SYNC_STAGES flops to give rxs. All FSM activity advances only on clk cycles where rx_tick=1.
- Tick counter tcnt runs 0..OVERSAMPLE-1. Bit counter bcnt runs 0..DATA_BITS-1. Stop counter scnt runs 0..STOP_BITS-1.
- IDLE: on a tick with rxs=0, go to START with tcnt=0.
- START: count ticks. At tcnt=OVERSAMPLE/2-1, re-sample rxs:
  - rxs=1: false start, go to IDLE.
  - rxs=0: go to DATA with tcnt=0.
- DATA: sample rxs at every tcnt=OVERSAMPLE-1 (bit centre) and shift right into the shift register (first bit ends in bit 0). After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at bit centre. perr = (XOR of data ^ sample) != PARITY_ODD. Go to STOP.
- STOP: sample STOP_BITS times at bit centres. Any low sample sets ferr.
  - At the final stop sample, evaluate break: all data bits 0, parity sample 0 (if enabled), and ferr=1.
  - Break: go to BRK_WAIT. Otherwise go to IDLE.
  - No wait for the end of the stop bit; this allows resync on a back-to-back start.
- BRK_WAIT: stay until a tick with rxs=1, then go to IDLE.
- Output load, on the clk cycle following the final stop-sample tick (registered, 1 cycle):
  - If rx_valid=0: load rx_dout, parity_err=perr, frame_err=ferr, break_det=brk, and set rx_valid=1.
  - If rx_valid=1 and no handshake occurs in that same cycle: the new frame is discarded, old data and flags are held, and overrun is set to 1.
  - Handshake and load in the same cycle: the new frame is loaded, rx_valid stays 1, overrun is unchanged.
- Handshake (rx_valid && rx_ready): rx_valid goes to 0 next cycle unless a load coincides. overrun clears on this handshake.
- A break produces exactly one word (rx_dout=0, frame_err=1, break_det=1). No further frame is detected until the line returns high.
- rx_dout and the flags are stable while rx_valid=1 and not yet accepted.
- busy=1 in START, DATA, PARITY, STOP and BRK_WAIT.

Test Plan:
1. 8N1, OVERSAMPLE=16, rx_ready=1, send 0xA5 -> rx_valid pulses one cycle with rx_dout=0xA5; parity_err, frame_err and break_det are 0.
2. PARITY_EN=1, even parity: send 0x3C with parity bit 0 -> parity_err=0. Send 0x3C with parity bit 1 -> rx_dout=0x3C, parity_err=1.
3. Line low for only 4 ticks, then high -> returns to IDLE, no rx_valid, busy falls within 8 ticks.
4. rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_dout holds 0x11 and overrun=1. Raise rx_ready -> handshake of 0x11, overrun clears, 0x22 is lost.
5. Hold rx low for 20 bit times, then release -> exactly one word: rx_dout=0x00, frame_err=1, break_det=1. Then send 0x5A -> received correctly.
6. STOP_BITS=2, second stop bit driven 0 on 0x7E -> frame_err=1. Separately, assert reset mid-DATA -> all outputs 0, IDLE, and the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver. It synchronises rx and finds the start bit with
// false-start rejection. It samples data, parity and stop bits at bit centre,
// flags framing, parity, break and overrun conditions, and hands the word out
// on a valid/ready pair.
// Ports: clk/reset (async active-low); rx serial in; rx_tick oversample enable;
//        rx_dout/rx_valid/rx_ready word handshake; parity_err, frame_err,
//        break_det, overrun status for the held word; busy = not idle.
module uart_rx_os #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_tick,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [TW-1:0]          tcnt, tcnt_n;
  logic [BW-1:0]          bcnt, bcnt_n;
  logic                   scnt, scnt_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   perr, perr_n;
  logic                   ferr, ferr_n;
  logic                   pbit, pbit_n;
  logic                   frame_done;
  logic                   brk;
  logic                   centre;
  logic                   hs;

  // Synchroniser presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  assign centre = (tcnt == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      scnt  <= 1'b0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      pbit  <= 1'b0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      scnt  <= scnt_n;
      shreg <= shreg_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
      pbit  <= pbit_n;
    end
  end

  always_comb begin
    state_n    = state;
    tcnt_n     = tcnt;
    bcnt_n     = bcnt;
    scnt_n     = scnt;
    shreg_n    = shreg;
    perr_n     = perr;
    ferr_n     = ferr;
    pbit_n     = pbit;
    frame_done = 1'b0;
    brk        = 1'b0;
    if (rx_tick) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            tcnt_n  = '0;
          end
        end
        START: begin
          // Half a bit after the falling edge the line must still be low.
          if (tcnt == TW'(OVERSAMPLE / 2 - 1)) begin
            tcnt_n = '0;
            if (rxs) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              bcnt_n  = '0;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
              pbit_n  = 1'b0;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        DATA: begin
          if (centre) begin
            tcnt_n  = '0;
            shreg_n = {rxs, shreg[DATA_BITS-1:1]};
            if (bcnt == BW'(DATA_BITS - 1)) begin
              bcnt_n  = '0;
              scnt_n  = 1'b0;
              state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        PARITY: begin
          if (centre) begin
            tcnt_n  = '0;
            pbit_n  = rxs;
            perr_n  = ((^shreg) ^ rxs) != PAR_ODD;
            scnt_n  = 1'b0;
            state_n = STOP;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        STOP: begin
          if (centre) begin
            tcnt_n = '0;
            ferr_n = ferr | ~rxs;
            if (scnt == 1'(STOP_BITS - 1)) begin
              // Leave right after the last stop sample so a back-to-back
              // start edge half a bit later is not missed.
              frame_done = 1'b1;
              scnt_n     = 1'b0;
              brk        = (shreg == '0) && ((PARITY_EN == 0) || !pbit) && ferr_n;
              state_n    = brk ? BRK_WAIT : IDLE;
            end else begin
              scnt_n = scnt + 1'b1;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        BRK_WAIT: begin
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign hs = rx_valid & rx_ready;

  // A finished frame is kept only if the output register is free or being
  // emptied in the same cycle; otherwise it is dropped and overrun flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_dout    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else if (frame_done) begin
      if (!rx_valid || hs) begin
        rx_dout    <= shreg;
        parity_err <= perr;
        frame_err  <= ferr_n;
        break_det  <= brk;
        rx_valid   <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (hs) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic rx_tick = 1'b0;
  logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
  logic [7:0] da, db, dc;
  logic va, vb, vc, pa, pb, pc, fa, fb, fc, ba, bb, bc, oa, ob, oc, ua, ub, uc;

  int checks = 0;
  int failures = 0;
  int tdiv = 0;

  // monitor state
  int wa = 0, wb = 0, wc = 0, vcyc_a = 0;
  logic [7:0] la_d, lb_d, lc_d;
  logic la_p, la_f, la_b, lb_p, lb_f, lb_b, lc_p, lc_f, lc_b;

  always #5 clk = ~clk;

  // rx_tick: one clk in four, so one bit = 16 ticks = 64 clocks
  always @(negedge clk) begin
    tdiv = (tdiv + 1) % 4;
    rx_tick = (tdiv == 0);
  end

  uart_rx_os u_a (
    .clk(clk), .reset(rst_n), .rx(rx), .rx_tick(rx_tick),
    .rx_dout(da), .rx_valid(va), .rx_ready(rdy_a),
    .parity_err(pa), .frame_err(fa), .break_det(ba), .overrun(oa), .busy(ua));

  uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .reset(rst_n), .rx(rx), .rx_tick(rx_tick),
    .rx_dout(db), .rx_valid(vb), .rx_ready(rdy_b),
    .parity_err(pb), .frame_err(fb), .break_det(bb), .overrun(ob), .busy(ub));

  uart_rx_os #(.STOP_BITS(2)) u_c (
    .clk(clk), .reset(rst_n), .rx(rx), .rx_tick(rx_tick),
    .rx_dout(dc), .rx_valid(vc), .rx_ready(rdy_c),
    .parity_err(pc), .frame_err(fc), .break_det(bc), .overrun(oc), .busy(uc));

  // Record accepted words; sampled just after the negedge so it sees the same
  // ready/valid the DUT sees at the following posedge.
  always @(negedge clk) begin
    #1;
    if (va) vcyc_a++;
    if (va && rdy_a) begin wa++; la_d = da; la_p = pa; la_f = fa; la_b = ba; end
    if (vb && rdy_b) begin wb++; lb_d = db; lb_p = pb; lb_f = fb; lb_b = bb; end
    if (vc && rdy_c) begin wc++; lc_d = dc; lc_p = pc; lc_f = fc; lc_b = bc; end
  end

  task automatic line_bit(input logic v);
    rx = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * 64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input logic par, input int nstop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    if (par_en) line_bit(par);
    for (int i = 0; i < nstop; i++) line_bit(1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (da !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h want=00", da); end
    checks++; if (va !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", va); end
    checks++; if ({pa, fa, ba, oa} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b want=0000", {pa, fa, ba, oa}); end
    checks++; if (ua !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", ua); end
    rst_n = 1'b1;
    idle_bits(2);
  endtask

  task automatic test_basic;
    int w0, v0;
    w0 = wa; v0 = vcyc_a;
    send_frame(8'hA5, 0, 1'b0, 1);
    idle_bits(2);
    checks++; if (wa - w0 !== 1) begin failures++; $display("FAIL t1_words got=%0d want=1", wa - w0); end
    checks++; if (vcyc_a - v0 !== 1) begin failures++; $display("FAIL t1_valid_cycles got=%0d want=1", vcyc_a - v0); end
    checks++; if (la_d !== 8'hA5) begin failures++; $display("FAIL t1_dout got=%h want=a5", la_d); end
    checks++; if ({la_p, la_f, la_b} !== 3'b000) begin failures++; $display("FAIL t1_flags got=%b want=000", {la_p, la_f, la_b}); end
  endtask

  task automatic test_parity;
    int w0;
    w0 = wb;
    send_frame(8'h3C, 1, 1'b0, 1);
    idle_bits(2);
    checks++; if (wb - w0 !== 1) begin failures++; $display("FAIL t2_words_good got=%0d want=1", wb - w0); end
    checks++; if ({lb_d, lb_p, lb_f} !== {8'h3C, 1'b0, 1'b0}) begin failures++; $display("FAIL t2_good got=%h/%b/%b want=3c/0/0", lb_d, lb_p, lb_f); end
    send_frame(8'h3C, 1, 1'b1, 1);
    idle_bits(2);
    checks++; if (wb - w0 !== 2) begin failures++; $display("FAIL t2_words_bad got=%0d want=2", wb - w0); end
    checks++; if ({lb_d, lb_p, lb_f, lb_b} !== {8'h3C, 1'b1, 1'b0, 1'b0}) begin failures++; $display("FAIL t2_bad got=%h/%b/%b/%b want=3c/1/0/0", lb_d, lb_p, lb_f, lb_b); end
  endtask

  task automatic test_false_start;
    int w0;
    w0 = wa;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    checks++; if (ua !== 1'b1) begin failures++; $display("FAIL t3_busy_rise got=%b want=1", ua); end
    rx = 1'b1;
    repeat (32) @(negedge clk);
    checks++; if ({ua, ub, uc} !== 3'b000) begin failures++; $display("FAIL t3_busy_fall got=%b want=000", {ua, ub, uc}); end
    idle_bits(2);
    checks++; if (wa - w0 !== 0 || va !== 1'b0) begin failures++; $display("FAIL t3_no_word got=%0d/%b want=0/0", wa - w0, va); end
  endtask

  task automatic test_overrun;
    int w0;
    w0 = wa;
    rdy_a = 1'b0;
    send_frame(8'h11, 0, 1'b0, 1);
    send_frame(8'h22, 0, 1'b0, 1);
    idle_bits(1);
    checks++; if ({va, oa} !== 2'b11) begin failures++; $display("FAIL t4_ovr_set got=%b want=11", {va, oa}); end
    checks++; if (da !== 8'h11) begin failures++; $display("FAIL t4_held got=%h want=11", da); end
    rdy_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wa - w0 !== 1 || la_d !== 8'h11) begin failures++; $display("FAIL t4_accept got=%0d/%h want=1/11", wa - w0, la_d); end
    checks++; if ({va, oa} !== 2'b00) begin failures++; $display("FAIL t4_ovr_clear got=%b want=00", {va, oa}); end
    idle_bits(2);
    checks++; if (wa - w0 !== 1) begin failures++; $display("FAIL t4_lost got=%0d want=1", wa - w0); end
  endtask

  task automatic test_break;
    int w0;
    w0 = wa;
    rx = 1'b0;
    repeat (20 * 64) @(negedge clk);
    idle_bits(2);
    checks++; if (wa - w0 !== 1) begin failures++; $display("FAIL t5_words got=%0d want=1", wa - w0); end
    checks++; if (la_d !== 8'h00) begin failures++; $display("FAIL t5_dout got=%h want=00", la_d); end
    checks++; if ({la_f, la_b, la_p} !== 3'b110) begin failures++; $display("FAIL t5_flags got=%b want=110", {la_f, la_b, la_p}); end
    send_frame(8'h5A, 0, 1'b0, 1);
    idle_bits(2);
    checks++; if (wa - w0 !== 2) begin failures++; $display("FAIL t5_after_words got=%0d want=2", wa - w0); end
    checks++; if ({la_d, la_f, la_b} !== {8'h5A, 1'b0, 1'b0}) begin failures++; $display("FAIL t5_after got=%h/%b/%b want=5a/0/0", la_d, la_f, la_b); end
  endtask

  task automatic test_stop2_and_reset;
    int w0;
    w0 = wc;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(8'h7E >> i);
    line_bit(1'b1);
    rx = 1'b0;                       // second stop bit low
    repeat (48) @(negedge clk);
    checks++; if (wc - w0 !== 1) begin failures++; $display("FAIL t6_stop2_words got=%0d want=1", wc - w0); end
    checks++; if ({lc_d, lc_f, lc_b} !== {8'h7E, 1'b1, 1'b0}) begin failures++; $display("FAIL t6_stop2 got=%h/%b/%b want=7e/1/0", lc_d, lc_f, lc_b); end
    idle_bits(12);
    // abort a frame in the middle of its data bits
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    line_bit(1'b0);
    checks++; if (uc !== 1'b1) begin failures++; $display("FAIL t6_busy_mid got=%b want=1", uc); end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({vc, pc, fc, bc, oc, uc} !== 6'b0 || dc !== 8'h00) begin failures++; $display("FAIL t6_reset got=%b/%h want=000000/00", {vc, pc, fc, bc, oc, uc}, dc); end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    w0 = wc;
    checks++; if (uc !== 1'b0 || vc !== 1'b0) begin failures++; $display("FAIL t6_idle_after got=%b/%b want=0/0", uc, vc); end
    send_frame(8'h81, 0, 1'b0, 2);
    idle_bits(2);
    checks++; if (wc - w0 !== 1) begin failures++; $display("FAIL t6_next_words got=%0d want=1", wc - w0); end
    checks++; if ({lc_d, lc_f, lc_p, lc_b} !== {8'h81, 3'b000}) begin failures++; $display("FAIL t6_next got=%h/%b/%b/%b want=81/0/0/0", lc_d, lc_f, lc_p, lc_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_overrun();
    test_break();
    test_stop2_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
